// File: rtl/serializer_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// serializer_tx : byte FIFO feeding an MSB-first serial shifter with write strobe
// Revision 1.0
// ============================================================================
module serializer_tx #(
   parameter int DEPTH        = 8,
   parameter int CLKS_PER_BIT = 10,
   parameter int GAP_CYCLES   = 10
) (
   input  logic       clock_1M,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       enq_in,
   input  logic       ready_in,
   output logic       serial_out,
   output logic       write_out,
   output logic [3:0] len_out,
   output logic       status_out
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [3:0]    DEPTH_L  = 4'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [3:0]      len_q, len_d;
   logic            full_q, full_d;
   // Bit 7 of the current byte lives in serial_q; this holds the remaining 7.
   logic [6:0]      shreg_q, shreg_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic [2:0]      bit_q, bit_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic            serial_q, serial_d;
   logic            write_q, write_d;
   logic            enq_ok;
   logic            pop;
   logic [7:0]      head;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      shreg_d  = shreg_q;
      cyc_d    = cyc_q;
      bit_d    = bit_q;
      gap_d    = gap_q;
      serial_d = serial_q;
      write_d  = write_q;
      pop      = 1'b0;
      enq_ok   = enq_in && !full_q;
      head     = mem_q[rd_ptr_q];

      case (state_q)
         IDLE: begin
            if (len_q != 4'd0 && ready_in) pop = 1'b1;
         end
         SHIFT: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d = '0;
               if (bit_q == 3'd7) begin
                  state_d  = GAP;
                  write_d  = 1'b0;
                  serial_d = 1'b0;
                  gap_d    = '0;
               end else begin
                  bit_d    = bit_q + 3'd1;
                  serial_d = shreg_q[6];
                  shreg_d  = {shreg_q[5:0], 1'b0};
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               if (len_q != 4'd0 && ready_in) pop = 1'b1;
               else                           state_d = IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         state_d  = SHIFT;
         serial_d = head[7];
         shreg_d  = head[6:0];
         write_d  = 1'b1;
         cyc_d    = '0;
         bit_d    = '0;
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
      end

      if (enq_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);

      len_d  = len_q + {3'b000, enq_ok} - {3'b000, pop};
      full_d = (len_d == DEPTH_L);
   end

   always_ff @(posedge clock_1M) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         len_q    <= '0;
         full_q   <= 1'b0;
         shreg_q  <= '0;
         cyc_q    <= '0;
         bit_q    <= '0;
         gap_q    <= '0;
         serial_q <= 1'b0;
         write_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         len_q    <= len_d;
         full_q   <= full_d;
         shreg_q  <= shreg_d;
         cyc_q    <= cyc_d;
         bit_q    <= bit_d;
         gap_q    <= gap_d;
         serial_q <= serial_d;
         write_q  <= write_d;
      end
   end

   // Storage needs no reset: a byte is only read after len_q shows it written.
   always_ff @(posedge clock_1M) begin
      if (enq_ok) mem_q[wr_ptr_q] <= data_in;
   end

   assign serial_out = serial_q;
   assign write_out  = write_q;
   assign len_out    = len_q;
   assign status_out = full_q;

endmodule
`default_nettype wire

// File: tb/tb_serializer_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_serializer_tx : queue-based reference model plus attached bit-sampling receiver
// Revision 1.0
// ============================================================================
module tb_serializer_tx;

   localparam int DEPTH = 8;
   localparam int CPB   = 10;
   localparam int GAP   = 10;
   localparam int BYTE_T = 8 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       enq_in = 1'b0;
   logic       ready_in = 1'b0;
   logic       serial_out, write_out, status_out;
   logic [3:0] len_out;

   int vectors = 0;
   int miscompares = 0;

   always #500 clk = ~clk;

   serializer_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .GAP_CYCLES(GAP)) dut (
      .clock_1M  (clk),
      .reset     (reset),
      .data_in   (data_in),
      .enq_in    (enq_in),
      .ready_in  (ready_in),
      .serial_out(serial_out),
      .write_out (write_out),
      .len_out   (len_out),
      .status_out(status_out)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: mode 0 = idle, 1 = sending (t = cycles into byte), 2 = gap (t = gap cycle)
   logic [7:0] mq[$];
   logic [7:0] m_cur = 8'h00;
   int         m_mode = 0;
   int         m_t = 0;
   bit         m_live = 1'b0;

   always @(posedge clk) begin
      bit full_b, start;
      if (reset) begin
         mq.delete();
         m_mode = 0;
         m_t    = 0;
         m_live = 1'b1;
      end else if (m_live) begin
         full_b = (mq.size() == DEPTH);
         start  = (mq.size() > 0) && ready_in;
         if (m_mode == 1) begin
            if (m_t == BYTE_T - 1) begin m_mode = 2; m_t = 0; end
            else m_t++;
         end else if (m_mode == 2) begin
            if (m_t == GAP - 1) begin
               if (start) begin m_cur = mq.pop_front(); m_mode = 1; m_t = 0; end
               else m_mode = 0;
            end else m_t++;
         end else if (start) begin
            m_cur = mq.pop_front(); m_mode = 1; m_t = 0;
         end
         if (enq_in && !full_b) mq.push_back(data_in);
      end
   end

   // Per-cycle compare plus a receiver that samples mid-bit and logs window lengths.
   logic [7:0] rx_q[$];
   int         his[$];
   int         gaps[$];
   bit         prev_w = 1'b0;
   bit         seen_fall = 1'b0;
   int         hi_run = 0;
   int         low_run = 0;
   int         rx_bits = 0;
   logic [7:0] rx_sh = 8'h00;

   always @(posedge clk) begin
      logic [7:0] cur;
      #1;
      if (m_live) begin
         cur = m_cur;
         chk("cyc_write", {31'd0, write_out}, {31'd0, m_mode == 1});
         chk("cyc_serial", {31'd0, serial_out},
             (m_mode == 1) ? {31'd0, cur[7 - m_t / CPB]} : 32'd0);
         chk("cyc_len", {28'd0, len_out}, mq.size());
         chk("cyc_full", {31'd0, status_out}, {31'd0, mq.size() == DEPTH});
      end
      if (write_out === 1'b1) begin
         if (!prev_w) begin
            if (seen_fall) gaps.push_back(low_run);
            hi_run  = 0;
            rx_bits = 0;
         end
         if (hi_run % CPB == CPB / 2) begin
            rx_sh = {rx_sh[6:0], serial_out};
            rx_bits++;
            if (rx_bits == 8) rx_q.push_back(rx_sh);
         end
         hi_run++;
      end else begin
         if (prev_w) begin
            his.push_back(hi_run);
            seen_fall = 1'b1;
            low_run   = 0;
         end
         low_run++;
      end
      prev_w = (write_out === 1'b1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic enq(input logic [7:0] d);
      data_in = d;
      enq_in  = 1'b1;
      cyc(1);
      enq_in  = 1'b0;
   endtask

   initial begin
      int m, mh, mg;
      logic [7:0] burst [3];
      burst[0] = 8'hAA; burst[1] = 8'h55; burst[2] = 8'hCC;

      cyc(3);
      reset = 1'b0;
      chk("rst_len", {28'd0, len_out}, 32'd0);
      chk("rst_write", {31'd0, write_out}, 32'd0);
      chk("rst_serial", {31'd0, serial_out}, 32'd0);
      chk("rst_full", {31'd0, status_out}, 32'd0);

      // Single byte
      ready_in = 1'b1;
      m = rx_q.size(); mh = his.size();
      enq(8'hAA);
      chk("single_len1", {28'd0, len_out}, 32'd1);
      chk("single_wr0", {31'd0, write_out}, 32'd0);
      cyc(1);
      chk("single_wr1", {31'd0, write_out}, 32'd1);
      chk("single_bit7", {31'd0, serial_out}, 32'd1);
      chk("single_len0", {28'd0, len_out}, 32'd0);
      cyc(100);
      chk("single_rx", {24'd0, rx_q[m]}, 32'hAA);
      chk("single_hi", his[mh], 32'd80);

      // Burst with gaps
      ready_in = 1'b0;
      m = rx_q.size(); mh = his.size(); mg = gaps.size() + 1;
      for (int i = 0; i < 3; i++) begin
         enq(burst[i]);
         chk("burst_len", {28'd0, len_out}, i + 1);
      end
      ready_in = 1'b1;
      cyc(3 * (BYTE_T + GAP) + 20);
      for (int i = 0; i < 3; i++) begin
         chk("burst_rx", {24'd0, rx_q[m + i]}, {24'd0, burst[i]});
         chk("burst_hi", his[mh + i], 32'd80);
      end
      chk("burst_gap0", gaps[mg], 32'd10);
      chk("burst_gap1", gaps[mg + 1], 32'd10);

      // Fill past capacity
      ready_in = 1'b0;
      m = rx_q.size();
      for (int i = 1; i <= 9; i++) enq(8'(i));
      chk("full_len", {28'd0, len_out}, 32'd8);
      chk("full_status", {31'd0, status_out}, 32'd1);
      ready_in = 1'b1;
      cyc(1);
      chk("full_pop_status", {31'd0, status_out}, 32'd0);
      chk("full_pop_len", {28'd0, len_out}, 32'd7);
      cyc(8 * (BYTE_T + GAP) + 20);
      chk("full_rx_count", rx_q.size() - m, 32'd8);
      for (int i = 0; i < 8; i++) chk("full_rx", {24'd0, rx_q[m + i]}, i + 1);

      // Flow control
      ready_in = 1'b0;
      m = rx_q.size();
      enq(8'h3C);
      enq(8'hC3);
      cyc(20);
      chk("fc_hold_wr", {31'd0, write_out}, 32'd0);
      chk("fc_hold_len", {28'd0, len_out}, 32'd2);
      ready_in = 1'b1;
      cyc(1);
      chk("fc_start_wr", {31'd0, write_out}, 32'd1);
      chk("fc_start_len", {28'd0, len_out}, 32'd1);
      cyc(30);
      ready_in = 1'b0;
      cyc(150);
      chk("fc_block_wr", {31'd0, write_out}, 32'd0);
      chk("fc_block_len", {28'd0, len_out}, 32'd1);
      chk("fc_rx0", {24'd0, rx_q[m]}, 32'h3C);
      ready_in = 1'b1;
      cyc(100);
      chk("fc_rx1", {24'd0, rx_q[m + 1]}, 32'hC3);

      // Simultaneous enqueue and pop
      ready_in = 1'b0;
      m = rx_q.size();
      enq(8'h11);
      chk("sim_len_pre", {28'd0, len_out}, 32'd1);
      ready_in = 1'b1;
      enq(8'h22);
      chk("sim_len", {28'd0, len_out}, 32'd1);
      chk("sim_wr", {31'd0, write_out}, 32'd1);
      cyc(200);
      chk("sim_rx0", {24'd0, rx_q[m]}, 32'h11);
      chk("sim_rx1", {24'd0, rx_q[m + 1]}, 32'h22);

      ready_in = 1'b0;
      m = rx_q.size();
      for (int i = 0; i < 8; i++) enq(8'hA0 + 8'(i));
      chk("simf_len_pre", {28'd0, len_out}, 32'd8);
      ready_in = 1'b1;
      enq(8'hEE);
      chk("simf_len", {28'd0, len_out}, 32'd7);
      chk("simf_status", {31'd0, status_out}, 32'd0);
      cyc(8 * (BYTE_T + GAP) + 20);
      chk("simf_rx_count", rx_q.size() - m, 32'd8);
      for (int i = 0; i < 8; i++) chk("simf_rx", {24'd0, rx_q[m + i]}, 32'hA0 + i);

      // Reset in the middle of a byte
      ready_in = 1'b0;
      enq(8'h5A); enq(8'hA5); enq(8'hF0); enq(8'h0F);
      ready_in = 1'b1;
      cyc(1);
      chk("rstm_len_pre", {28'd0, len_out}, 32'd3);
      cyc(34);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("rstm_wr", {31'd0, write_out}, 32'd0);
      chk("rstm_len", {28'd0, len_out}, 32'd0);
      chk("rstm_status", {31'd0, status_out}, 32'd0);
      chk("rstm_serial", {31'd0, serial_out}, 32'd0);
      m = rx_q.size();
      cyc(200);
      chk("rstm_quiet_wr", {31'd0, write_out}, 32'd0);
      chk("rstm_quiet_rx", rx_q.size() - m, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
